pe_feeder: RTL and testbench
============================

# pe_feeder

Operand feeder for the edge of the systolic PE array. On a start pulse it reads `k_len` consecutive operand vectors from the local operand RAM and streams them into the array's input lanes as registered `vld`/`data` pairs. Lane i is skewed by i cycles so operands meet diagonally inside the array. It is the transmitting end of the PE `in*_vld`/`in*_data` interface; one instance feeds the row edge and one feeds the column edge.

## Interface
- `LANES`, 4: number of array lanes driven (≥1)
- `AW`, 8: operand RAM address width
- `KW`, 8: vector-count width
- `clk` in 1: clock
- `rst_n` in 1: reset, synchronous, active-low
- `start` in 1: single-cycle start request; accepted only in IDLE
- `base_addr` in AW: first RAM address; sampled with accepted `start`
- `k_len` in KW: number of vectors to send; sampled with accepted `start`
- `rd_en` out 1: RAM read strobe
- `rd_addr` out AW: RAM read address
- `rd_data` in LANES*8: RAM read data, valid the cycle after `rd_en`; lane i = bits [8i+7:8i]
- `lane_vld` out LANES: per-lane valid into the array
- `lane_data` out LANES*8: per-lane operand into the array
- `pe_en` out 1: array enable; high in READ and DRAIN
- `busy` out 1: high in READ, DRAIN, DONE
- `done` out 1: one-cycle completion pulse

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE: `start`=1 latches `base_addr` and `k_len`. The next state is READ if `k_len`≠0, else DONE.
- READ: `rd_en`=1 and `rd_addr`=base+cnt, with cnt counting 0..k_len-1. After the cycle with cnt=k_len-1 the block goes to DRAIN.
- Address arithmetic is modulo 2^AW; it wraps silently.
- Data path: a 1-bit valid tracks `rd_en` one cycle later, aligned with `rd_data`. Stage 0 registers `rd_data` and the valid.
  - Lane i then passes through i further register stages for valid and data.
  - Lane i output is the output of its last stage.
- DRAIN: a counter runs LANES+1 cycles, then the block goes to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` in any state other than IDLE is ignored; there is no queuing.
- Data registers load only when their stage valid is 1; otherwise they hold. The valid bits do not hold.
- Reset mid-operation: the next edge returns to IDLE and clears every valid stage and counter. No `done` is generated for the aborted job.
- Reset values: `rd_en`, `rd_addr`, `lane_vld`, `lane_data`, `pe_en`, `busy`, `done` are all 0.

## Timing
- Accepted `start` in cycle 0 → state READ in cycle 1. `rd_en` is high in cycles 1..k; `busy` and `pe_en` go high from cycle 1.
- `rd_en` in cycle t → `rd_data` valid in cycle t+1 → lane 0 output in cycle t+2 → lane i output in cycle t+2+i.
- Lane i has `lane_vld`=1 in cycles 3+i..k+2+i, with vector j presented in cycle 3+i+j.
- DRAIN covers cycles k+1..k+1+LANES. `done`=1 in cycle k+2+LANES, and IDLE is entered in cycle k+3+LANES.
- `pe_en` drops in the DONE cycle.
- k_len=0: `done`=1 in cycle 1, with `busy`=1 only in cycle 1, no `rd_en`, and no `lane_vld`.
- Back-to-back: `start` in the first IDLE cycle after DONE is accepted.

## Configuration
- `PE_FEEDER_SKEW_EN` defined: per-lane skew as described above (lane i delayed i extra cycles). DRAIN lasts LANES+1 cycles.
- Not defined: no skew stages. All lanes output from stage 0 in the same cycle, `lane_vld` is high in cycles 3..k+2 on every lane, and DRAIN lasts 2 cycles, so `done` comes in cycle k+3.

## Test plan
- Skew on, LANES=4, base=0x10, k_len=3, start in cycle 0:
  - `rd_addr` is 0x10/0x11/0x12 in cycles 1–3.
  - `lane_vld[0]` is high in cycles 3–5 and `lane_vld[3]` in cycles 6–8.
  - Each lane's data equals its RAM byte of the matching vector.
  - `done` in cycle 9.
- k_len=0: `done` in cycle 1; `rd_en` and `lane_vld` stay 0; `busy` is high only in cycle 1.
- base=0xFE, k_len=4: `rd_addr` sequence is 0xFE, 0xFF, 0x00, 0x01, and data follows the wrapped addresses.
- `start` pulsed in cycle 2 of a k_len=5 job: ignored; the job completes unchanged and exactly one `done` is generated.
- `rst_n`=0 in cycle 4 of a k_len=8 job: in the next cycle every output is 0, with no `done`; a new `start` after release runs normally.
- Skew off, LANES=4, k_len=2: all four `lane_vld` bits are high in cycles 3–4 simultaneously, and `done` comes in cycle 5.

Source files
------------

// File: rtl/pe_feeder_if.sv
// Operand-feeder bus: job request, operand RAM read port and array lane outputs.
// master = the feeder, slave = job issuer / RAM / array side.
interface pe_feeder_if #(
  parameter int LANES = 4,
  parameter int AW    = 8,
  parameter int KW    = 8
);
  logic                  start;
  logic [AW-1:0]         base_addr;
  logic [KW-1:0]         k_len;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;
  logic [LANES-1:0][7:0] rd_data;
  logic [LANES-1:0]      lane_vld;
  logic [LANES-1:0][7:0] lane_data;
  logic                  pe_en;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, base_addr, k_len, rd_data,
    output rd_en, rd_addr, lane_vld, lane_data, pe_en, busy, done
  );

  modport slave (
    output start, base_addr, k_len, rd_data,
    input  rd_en, rd_addr, lane_vld, lane_data, pe_en, busy, done
  );
endinterface

// File: rtl/pe_feeder.sv
// Systolic-array edge feeder: reads k_len operand vectors and streams them per lane.
// Optional macro PE_FEEDER_SKEW_EN delays lane i by i cycles for diagonal arrival.
module pe_feeder_lane #(
  parameter int DEPTH = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_vld,
  input  logic [7:0] in_data,
  output logic       out_vld,
  output logic [7:0] out_data
);
  logic [DEPTH:0]      vld_pipe;
  logic [DEPTH:0][7:0] data_pipe;

  // Data stages only capture on a valid; valid bits always shift.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      data_pipe <= '0;
    end else begin
      vld_pipe[0] <= in_vld;
      if (in_vld) data_pipe[0] <= in_data;
      for (int s = 1; s <= DEPTH; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) data_pipe[s] <= data_pipe[s-1];
      end
    end
  end

  assign out_vld  = vld_pipe[DEPTH];
  assign out_data = data_pipe[DEPTH];
endmodule

module pe_feeder #(
  parameter int LANES = 4,
  parameter int AW    = 8,
  parameter int KW    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  pe_feeder_if.master bus
);
`ifdef PE_FEEDER_SKEW_EN
  localparam bit SKEW = 1'b1;
`else
  localparam bit SKEW = 1'b0;
`endif
  // Drain must outlast the deepest lane pipeline before done is raised.
  localparam int DRAIN_LEN = SKEW ? LANES + 1 : 2;
  localparam int DW        = $clog2(DRAIN_LEN + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [AW-1:0] base;
    logic [KW-1:0] len;
  } job_t;

  state_t        state, state_nx;
  job_t          job;
  logic [KW-1:0] cnt;
  logic [DW-1:0] dcnt;
  logic          rvld;
  logic          last_rd, last_drain;

  assign last_rd    = (cnt == job.len - KW'(1));
  assign last_drain = (dcnt == DW'(DRAIN_LEN - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    bus.pe_en   = 1'b0;
    bus.busy    = 1'b1;
    bus.done    = 1'b0;
    unique case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_nx = (bus.k_len != '0) ? READ : DONE;
      end
      READ: begin
        bus.rd_en   = 1'b1;
        bus.rd_addr = job.base + AW'(cnt);
        bus.pe_en   = 1'b1;
        if (last_rd) state_nx = DRAIN;
      end
      DRAIN: begin
        bus.pe_en = 1'b1;
        if (last_drain) state_nx = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      job  <= '0;
      cnt  <= '0;
      dcnt <= '0;
      rvld <= 1'b0;
    end else begin
      // rvld lines up with rd_data, which the RAM returns one cycle after rd_en.
      rvld <= (state == READ);
      if (state == IDLE && bus.start) job <= '{base: bus.base_addr, len: bus.k_len};
      cnt  <= (state == READ  && !last_rd)    ? cnt + KW'(1)  : '0;
      dcnt <= (state == DRAIN && !last_drain) ? dcnt + DW'(1) : '0;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pe_feeder_lane #(.DEPTH(SKEW ? i : 0)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_vld   (rvld),
      .in_data  (bus.rd_data[i]),
      .out_vld  (bus.lane_vld[i]),
      .out_data (bus.lane_data[i])
    );
  end
endmodule

// File: tb/tb_pe_feeder.sv
// Directed self-checking bench for pe_feeder; expectations follow the build's skew setting.
module tb_pe_feeder;
  localparam int LANES = 4;
  localparam int AW    = 8;
  localparam int KW    = 8;
`ifdef PE_FEEDER_SKEW_EN
  localparam int SK = 1;
`else
  localparam int SK = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pe_feeder_if #(.LANES(LANES), .AW(AW), .KW(KW)) bus ();

  pe_feeder #(.LANES(LANES), .AW(AW), .KW(KW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [7:0] ram_byte(logic [7:0] a, int i);
    return 8'(a * (i + 3)) ^ 8'(92 + i * 17);
  endfunction

  // Operand RAM model: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.rd_en)
      for (int i = 0; i < LANES; i++) bus.rd_data[i] <= ram_byte(bus.rd_addr, i);
  end

  // Runs one job from start (cycle 0) through its done cycle, checking every output each cycle.
  // A conflicting start is pulsed in cycle `poke` (negative = none).
  task automatic run_job(input string nm, input logic [7:0] b, input int k, input int poke);
    int d;
    d = (k == 0) ? 1 : k + 2 + (SK != 0 ? LANES : 1);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = b; bus.k_len = 8'(k);
    for (int c = 0; c <= d; c++) begin
      logic             e_rd;
      logic [7:0]       e_addr;
      logic [LANES-1:0] e_vld;
      if (c > 0) begin
        @(posedge clk); #1;
        bus.start = (c == poke);
        if (c == poke) begin bus.base_addr = ~b; bus.k_len = 8'd1; end
      end
      @(negedge clk);
      e_rd   = (k > 0) && (c >= 1) && (c <= k);
      e_addr = e_rd ? 8'(b + 8'(c - 1)) : 8'h00;
      for (int i = 0; i < LANES; i++) begin
        int off;
        off = (SK != 0) ? i : 0;
        e_vld[i] = (k > 0) && (c >= 3 + off) && (c <= k + 2 + off);
      end
      checks++;
      if (bus.rd_en !== e_rd) begin
        errors++; $display("FAIL %s c%0d rd_en got %0b exp %0b", nm, c, bus.rd_en, e_rd);
      end
      checks++;
      if (bus.rd_addr !== e_addr) begin
        errors++; $display("FAIL %s c%0d rd_addr got %02h exp %02h", nm, c, bus.rd_addr, e_addr);
      end
      checks++;
      if (bus.lane_vld !== e_vld) begin
        errors++; $display("FAIL %s c%0d lane_vld got %b exp %b", nm, c, bus.lane_vld, e_vld);
      end
      for (int i = 0; i < LANES; i++) begin
        if (e_vld[i]) begin
          logic [7:0] e_d;
          e_d = ram_byte(8'(b + 8'(c - 3 - ((SK != 0) ? i : 0))), i);
          checks++;
          if (bus.lane_data[i] !== e_d) begin
            errors++;
            $display("FAIL %s c%0d lane_data[%0d] got %02h exp %02h", nm, c, i, bus.lane_data[i], e_d);
          end
        end
      end
      checks++;
      if (bus.busy !== ((c >= 1) && (c <= d))) begin
        errors++; $display("FAIL %s c%0d busy got %0b", nm, c, bus.busy);
      end
      checks++;
      if (bus.pe_en !== ((k > 0) && (c >= 1) && (c < d))) begin
        errors++; $display("FAIL %s c%0d pe_en got %0b", nm, c, bus.pe_en);
      end
      checks++;
      if (bus.done !== (c == d)) begin
        errors++; $display("FAIL %s c%0d done got %0b exp %0b", nm, c, bus.done, (c == d));
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.start = 1'b0; bus.base_addr = '0; bus.k_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.rd_en, bus.rd_addr, bus.lane_vld, bus.pe_en, bus.busy, bus.done} !== '0) begin
      errors++;
      $display("FAIL reset ctrl rd_en=%0b rd_addr=%02h lane_vld=%b pe_en=%0b busy=%0b done=%0b exp all 0",
               bus.rd_en, bus.rd_addr, bus.lane_vld, bus.pe_en, bus.busy, bus.done);
    end
    checks++;
    if (bus.lane_data !== '0) begin
      errors++; $display("FAIL reset lane_data got %h exp 0", bus.lane_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_job("basic", 8'h10, 3, -1);
  endtask

  task automatic test_zero_len();
    run_job("zero_len", 8'h44, 0, -1);
  endtask

  task automatic test_wrap();
    run_job("wrap", 8'hFE, 4, -1);
  endtask

  task automatic test_start_ignored();
    run_job("start_ign", 8'h40, 5, 2);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.rd_en !== 1'b0) begin
      errors++;
      $display("FAIL start_ign extra job done=%0b busy=%0b rd_en=%0b exp 0", bus.done, bus.busy, bus.rd_en);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = 8'h20; bus.k_len = 8'd8;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.rd_en, bus.rd_addr, bus.lane_vld, bus.pe_en, bus.busy, bus.done} !== '0) begin
      errors++;
      $display("FAIL reset_mid ctrl rd_en=%0b rd_addr=%02h lane_vld=%b pe_en=%0b busy=%0b done=%0b exp all 0",
               bus.rd_en, bus.rd_addr, bus.lane_vld, bus.pe_en, bus.busy, bus.done);
    end
    checks++;
    if (bus.lane_data !== '0) begin
      errors++; $display("FAIL reset_mid lane_data got %h exp 0", bus.lane_data);
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.lane_vld !== '0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid after c%0d done=%0b lane_vld=%b busy=%0b exp 0", c, bus.done, bus.lane_vld, bus.busy);
      end
    end
    run_job("after_rst", 8'h33, 2, -1);
  endtask

  task automatic test_back_to_back();
    run_job("b2b_a", 8'h50, 2, -1);
    run_job("b2b_b", 8'h60, 1, -1);
  endtask

  task automatic test_k2();
    run_job("k2", 8'h80, 2, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_k2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
